// File: rtl/bf_relax_scheduler_pkg.sv
// Shared widths, distance limits, edge-word layout and FSM state encoding for the Bellman-Ford scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bf_relax_scheduler_pkg;

    localparam int NODE_W  = 8;   // node index width (up to 256 nodes)
    localparam int EDGE_AW = 13;  // edge-memory address width
    localparam int DIST_W  = 16;  // signed distance / weight width
    localparam int EDGE_DW = 32;  // edge-memory word width

    // 7FFF is reserved as "unreachable"; finite distances stop one below it.
    localparam logic signed [DIST_W-1:0] DIST_INF = 16'sh7FFF;
    localparam logic signed [DIST_W-1:0] DIST_MAX = 16'sh7FFE;
    localparam logic signed [DIST_W-1:0] DIST_MIN = 16'sh8000;

    // Edge word layout: {src, dst, weight}.
    localparam int EDGE_SRC_LSB = 24;
    localparam int EDGE_DST_LSB = 16;
    localparam int EDGE_W_LSB   = 0;

    typedef struct packed {
        logic [NODE_W-1:0]        src;
        logic [NODE_W-1:0]        dst;
        logic signed [DIST_W-1:0] weight;
    } edge_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INIT     = 3'd1,
        ST_FETCH    = 3'd2,
        ST_RD_SRC   = 3'd3,
        ST_RD_DST   = 3'd4,
        ST_RELAX    = 3'd5,
        ST_PASS_END = 3'd6,
        ST_DONE     = 3'd7
    } state_t;

    function automatic edge_t decode_edge(input logic [EDGE_DW-1:0] word);
        edge_t e;
        e.src    = word[EDGE_SRC_LSB +: NODE_W];
        e.dst    = word[EDGE_DST_LSB +: NODE_W];
        e.weight = word[EDGE_W_LSB +: DIST_W];
        return e;
    endfunction

endpackage

// File: rtl/bf_relax_scheduler_if.sv
// Memory-side bus of the scheduler: edge-list read port and distance-memory read/write port.
// Latency: edge_data and dist_rdata arrive one cycle after their address/strobe.
// Backpressure: none; memories are fixed-latency and always ready.
interface bf_relax_scheduler_if;
    import bf_relax_scheduler_pkg::*;

    logic [EDGE_AW-1:0] edge_addr;
    logic               edge_rd;
    logic [EDGE_DW-1:0] edge_data;
    logic [NODE_W-1:0]  dist_addr;
    logic               dist_we;
    logic [DIST_W-1:0]  dist_wdata;
    logic [DIST_W-1:0]  dist_rdata;

    // master: the scheduler; slave: the edge and distance memories.
    modport master (
        output edge_addr, edge_rd, dist_addr, dist_we, dist_wdata,
        input  edge_data, dist_rdata
    );

    modport slave (
        input  edge_addr, edge_rd, dist_addr, dist_we, dist_wdata,
        output edge_data, dist_rdata
    );

endinterface

// File: rtl/bf_relax_scheduler_alu.sv
// Relaxation arithmetic: cand = sat(dist_src + weight), improve when src reachable and cand < dist_dst.
// Latency: purely combinational.
// Backpressure: none.
module bf_relax_scheduler_alu
    import bf_relax_scheduler_pkg::*;
(
    input  logic signed [DIST_W-1:0] dist_src,
    input  logic signed [DIST_W-1:0] dist_dst,
    input  logic signed [DIST_W-1:0] weight,
    output logic signed [DIST_W-1:0] cand,
    output logic                     improve
);

    // One extra bit so the raw sum can never wrap before saturation.
    localparam logic signed [DIST_W:0] SUM_MAX = (DIST_W+1)'(DIST_MAX);
    localparam logic signed [DIST_W:0] SUM_MIN = (DIST_W+1)'(DIST_MIN);

    logic signed [DIST_W:0] sum;

    always_comb begin
        sum = (DIST_W+1)'(dist_src) + (DIST_W+1)'(weight);
        // Clamp at DIST_MAX, not INF, so a finite path never reads as unreachable.
        if (sum > SUM_MAX) begin
            cand = DIST_MAX;
        end else if (sum < SUM_MIN) begin
            cand = DIST_MIN;
        end else begin
            cand = sum[DIST_W-1:0];
        end
        improve = (dist_src != DIST_INF) && (cand < dist_dst);
    end

endmodule

// File: rtl/bf_relax_scheduler.sv
// Bellman-Ford sequencer: init distances, up to N-1 relaxation passes (early exit), then a negative-cycle check pass.
// Latency: N+1 init cycles, 4 cycles per edge, 1 cycle per pass end, 1 DONE cycle; bad config finishes 2 cycles after start.
// Backpressure: none; start is ignored while busy, memories are fixed 1-cycle latency.
//
// Ports: clock/reset (async, active-high); start + num_nodes/num_edges/source_node sampled on accepted start;
// mem = edge-list read and distance read/write bus; busy/finish/n_exist/bad_cfg/pass_count = run status.
module bf_relax_scheduler
    import bf_relax_scheduler_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NODE_W:0]      num_nodes,
    input  logic [EDGE_AW-1:0]   num_edges,
    input  logic [NODE_W-1:0]    source_node,
    bf_relax_scheduler_if.master mem,
    output logic                 busy,
    output logic                 finish,
    output logic                 n_exist,
    output logic                 bad_cfg,
    output logic [NODE_W:0]      pass_count
);

    state_t                   state, state_nxt;

    // Run configuration captured on start.
    logic [NODE_W:0]          nodes_q;
    logic [EDGE_AW-1:0]       edges_q;
    logic [NODE_W-1:0]        src_q;

    logic [NODE_W:0]          init_cnt;     // 0..N-1 writes INF, N writes source=0
    logic [EDGE_AW-1:0]       edge_idx;
    logic                     checking;     // current walk is the negative-cycle check pass
    logic                     pass_changed;

    edge_t                    edge_in;      // edge word as it arrives from memory
    edge_t                    edge_q;       // edge held for the rest of its 4-cycle slot
    logic signed [DIST_W-1:0] dsrc_q;

    logic signed [DIST_W-1:0] alu_cand;
    logic                     alu_improve;

    logic                     last_edge;
    logic                     init_last;
    logic [NODE_W:0]          pass_inc;
    logic                     relax_done;

    assign edge_in    = decode_edge(mem.edge_data);
    assign last_edge  = (edge_idx == edges_q - 1'b1);
    assign init_last  = (init_cnt == nodes_q);
    assign pass_inc   = pass_count + 1'b1;
    // Stop relaxing after a quiet pass or once N-1 passes have run.
    assign relax_done = !pass_changed || (pass_inc == nodes_q - 1'b1);

    // In RELAX the distance memory returns dist[dst] requested during RD_DST.
    bf_relax_scheduler_alu u_alu (
        .dist_src (dsrc_q),
        .dist_dst ($signed(mem.dist_rdata)),
        .weight   (edge_q.weight),
        .cand     (alu_cand),
        .improve  (alu_improve)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Outputs are decoded from the state register, so reset clears dist_we
    // asynchronously and no partial write can land.
    always_comb begin
        state_nxt      = state;
        mem.edge_addr  = edge_idx;
        mem.edge_rd    = 1'b0;
        mem.dist_addr  = edge_q.dst;
        mem.dist_we    = 1'b0;
        mem.dist_wdata = alu_cand;
        busy           = (state != ST_IDLE) && (state != ST_DONE);
        finish         = (state == ST_DONE);

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_INIT;
                end
            end
            ST_INIT: begin
                if (bad_cfg) begin
                    state_nxt = ST_DONE;
                end else if (init_last) begin
                    mem.dist_we    = 1'b1;
                    mem.dist_addr  = src_q;
                    mem.dist_wdata = '0;
                    state_nxt      = (edges_q == '0) ? ST_DONE : ST_FETCH;
                end else begin
                    mem.dist_we    = 1'b1;
                    mem.dist_addr  = init_cnt[NODE_W-1:0];
                    mem.dist_wdata = DIST_INF;
                end
            end
            ST_FETCH: begin
                mem.edge_rd = 1'b1;
                state_nxt   = ST_RD_SRC;
            end
            ST_RD_SRC: begin
                // Edge word is valid only this cycle; address dist[src] straight from it.
                mem.dist_addr = edge_in.src;
                state_nxt     = ST_RD_DST;
            end
            ST_RD_DST: begin
                mem.dist_addr = edge_q.dst;
                state_nxt     = ST_RELAX;
            end
            ST_RELAX: begin
                mem.dist_addr = edge_q.dst;
                mem.dist_we   = alu_improve && !checking;
                if (checking && alu_improve) begin
                    state_nxt = ST_DONE;
                end else if (last_edge) begin
                    state_nxt = checking ? ST_DONE : ST_PASS_END;
                end else begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_PASS_END: begin
                state_nxt = ST_FETCH;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            nodes_q      <= '0;
            edges_q      <= '0;
            src_q        <= '0;
            init_cnt     <= '0;
            edge_idx     <= '0;
            checking     <= 1'b0;
            pass_changed <= 1'b0;
            edge_q       <= '0;
            dsrc_q       <= '0;
            n_exist      <= 1'b0;
            bad_cfg      <= 1'b0;
            pass_count   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        nodes_q      <= num_nodes;
                        edges_q      <= num_edges;
                        src_q        <= source_node;
                        init_cnt     <= '0;
                        edge_idx     <= '0;
                        checking     <= 1'b0;
                        pass_changed <= 1'b0;
                        n_exist      <= 1'b0;
                        bad_cfg      <= ({1'b0, source_node} >= num_nodes);
                        pass_count   <= '0;
                    end
                end
                ST_INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    edge_idx <= '0;
                    // A single node has no relaxation passes; go straight to checking.
                    checking <= (nodes_q == 9'd1);
                end
                ST_RD_SRC: begin
                    edge_q <= edge_in;
                end
                ST_RD_DST: begin
                    dsrc_q <= $signed(mem.dist_rdata);
                end
                ST_RELAX: begin
                    edge_idx <= edge_idx + 1'b1;
                    if (alu_improve && !checking) begin
                        pass_changed <= 1'b1;
                    end
                    if (alu_improve && checking) begin
                        n_exist <= 1'b1;
                    end
                end
                ST_PASS_END: begin
                    pass_count   <= pass_inc;
                    edge_idx     <= '0;
                    pass_changed <= 1'b0;
                    if (relax_done) begin
                        checking <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bf_relax_scheduler.sv
// Directed bench for bf_relax_scheduler with behavioural edge and distance memories.
// Latency: n/a.
// Backpressure: n/a.
module tb_bf_relax_scheduler;
    import bf_relax_scheduler_pkg::*;

    logic               clock = 1'b0;
    logic               reset;
    logic               start;
    logic [NODE_W:0]    num_nodes;
    logic [EDGE_AW-1:0] num_edges;
    logic [NODE_W-1:0]  source_node;
    logic               busy, finish, n_exist, bad_cfg;
    logic [NODE_W:0]    pass_count;

    bf_relax_scheduler_if bus ();

    bf_relax_scheduler dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .num_nodes   (num_nodes),
        .num_edges   (num_edges),
        .source_node (source_node),
        .mem         (bus),
        .busy        (busy),
        .finish      (finish),
        .n_exist     (n_exist),
        .bad_cfg     (bad_cfg),
        .pass_count  (pass_count)
    );

    always #5 clock = ~clock;

    logic [31:0] emem [0:15];
    logic [15:0] dmem [0:255];
    int          wr_cnt  = 0;
    int          fin_cnt = 0;
    int          wr0, fin0;
    int          n_checks = 0;
    int          n_errors = 0;

    always @(posedge clock) begin
        if (bus.edge_rd) bus.edge_data <= emem[bus.edge_addr[3:0]];
        if (bus.dist_we) begin
            dmem[bus.dist_addr] <= bus.dist_wdata;
            wr_cnt <= wr_cnt + 1;
        end else begin
            bus.dist_rdata <= dmem[bus.dist_addr];
        end
        if (finish) fin_cnt <= fin_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_dist(input string tag, input int idx, input logic signed [15:0] exp);
        check($sformatf("%s_d%0d", tag, idx), 32'($signed(dmem[idx])), 32'(exp));
    endtask

    task automatic set_edge(input int i, input int s, input int d, input int w);
        emem[i] = {8'(s), 8'(d), 16'(w)};
    endtask

    task automatic start_cfg(input int n, input int e, input int s);
        @(negedge clock);
        num_nodes   = 9'(n);
        num_edges   = 13'(e);
        source_node = 8'(s);
        start       = 1'b1;
        wr0         = wr_cnt;
        fin0        = fin_cnt;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int c;
        c = 0;
        while (!finish && c < 3000) begin
            @(negedge clock);
            c++;
        end
        check({tag, "_finish"}, 32'(finish), 1);
        @(negedge clock);
        check({tag, "_idle"}, 32'(busy), 0);
        check({tag, "_fin_once"}, fin_cnt - fin0, 1);
    endtask

    task automatic load_t1();
        set_edge(0, 0, 1, 5);
        set_edge(1, 1, 2, -2);
        set_edge(2, 0, 2, 4);
        set_edge(3, 2, 3, 1);
    endtask

    task automatic check_t1(input string tag);
        check_dist(tag, 0, 0);
        check_dist(tag, 1, 5);
        check_dist(tag, 2, 3);
        check_dist(tag, 3, 4);
        check({tag, "_nexist"}, 32'(n_exist), 0);
        check({tag, "_passes"}, 32'(pass_count), 2);
        check({tag, "_writes"}, wr_cnt - wr0, 8);
        check({tag, "_badcfg"}, 32'(bad_cfg), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        num_nodes   = '0;
        num_edges   = '0;
        source_node = '0;
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_finish", 32'(finish), 0);
        check("rst_nexist", 32'(n_exist), 0);
        check("rst_badcfg", 32'(bad_cfg), 0);
        check("rst_passes", 32'(pass_count), 0);
        check("rst_we", 32'(bus.dist_we), 0);
        check("rst_erd", 32'(bus.edge_rd), 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Test 1: early exit after pass 2.
        load_t1();
        start_cfg(4, 4, 0);
        check("t1_busy", 32'(busy), 1);
        wait_done("t1");
        check_t1("t1");

        // Test 2: negative cycle, no writes in check pass.
        set_edge(0, 0, 1, 1);
        set_edge(1, 1, 2, -3);
        set_edge(2, 2, 0, 1);
        start_cfg(3, 3, 0);
        wait_done("t2");
        check("t2_nexist", 32'(n_exist), 1);
        check("t2_passes", 32'(pass_count), 2);
        check("t2_writes", wr_cnt - wr0, 10);
        check_dist("t2", 0, -2);
        check_dist("t2", 1, 0);
        check_dist("t2", 2, -3);

        // Test 3: edge from unreachable node never written.
        set_edge(0, 1, 2, 7);
        start_cfg(3, 1, 0);
        wait_done("t3");
        check_dist("t3", 0, 0);
        check_dist("t3", 1, 16'sh7FFF);
        check_dist("t3", 2, 16'sh7FFF);
        check("t3_writes", wr_cnt - wr0, 4);
        check("t3_passes", 32'(pass_count), 1);

        // Test 4: saturation at both ends.
        set_edge(0, 0, 1, 32000);
        set_edge(1, 1, 2, 1000);
        set_edge(2, 0, 3, -10);
        set_edge(3, 3, 4, -32768);
        start_cfg(5, 4, 0);
        wait_done("t4");
        check_dist("t4", 1, 32000);
        check_dist("t4", 2, 16'sh7FFE);
        check_dist("t4", 3, -10);
        check_dist("t4", 4, 16'sh8000);
        check("t4_nexist", 32'(n_exist), 0);
        check("t4_passes", 32'(pass_count), 2);

        // E=0 and N=1 negative self-loop.
        start_cfg(4, 0, 0);
        wait_done("e0");
        check("e0_passes", 32'(pass_count), 0);
        check("e0_writes", wr_cnt - wr0, 5);
        check("e0_nexist", 32'(n_exist), 0);
        set_edge(0, 0, 0, -1);
        start_cfg(1, 1, 0);
        wait_done("n1");
        check("n1_nexist", 32'(n_exist), 1);
        check("n1_passes", 32'(pass_count), 0);
        check("n1_writes", wr_cnt - wr0, 2);

        // Test 5: reset during a RELAX write.
        load_t1();
        start_cfg(4, 4, 0);
        begin
            int c;
            c = 0;
            while (!(bus.dist_we && (wr_cnt - wr0) >= 5) && c < 2000) begin
                @(negedge clock);
                c++;
            end
        end
        check("t5_we_before", 32'(bus.dist_we), 1);
        reset = 1'b1;
        #1;
        check("t5_we", 32'(bus.dist_we), 0);
        check("t5_busy", 32'(busy), 0);
        check("t5_finish", 32'(finish), 0);
        check("t5_passes", 32'(pass_count), 0);
        check("t5_nexist", 32'(n_exist), 0);
        @(negedge clock);
        check_dist("t5_nowrite", 1, 16'sh7FFF);
        // Start coinciding with reset is dropped.
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        check("t5_rst_start", 32'(busy), 0);
        start_cfg(4, 4, 0);
        wait_done("t5r");
        check_t1("t5r");

        // Test 6: bad config, exact finish timing.
        start_cfg(4, 4, 5);
        check("t6_busy", 32'(busy), 1);
        check("t6_fin_early", 32'(finish), 0);
        @(negedge clock);
        check("t6_finish", 32'(finish), 1);
        check("t6_busy_drop", 32'(busy), 0);
        @(negedge clock);
        check("t6_fin_pulse", 32'(finish), 0);
        check("t6_badcfg", 32'(bad_cfg), 1);
        check("t6_writes", wr_cnt - wr0, 0);

        // Start while busy is ignored.
        set_edge(0, 1, 2, 7);
        start_cfg(3, 1, 0);
        check("t6b_badcfg_clr", 32'(bad_cfg), 0);
        @(negedge clock);
        num_nodes   = 9'd4;
        source_node = 8'd5;
        start       = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done("t6b");
        check("t6b_badcfg", 32'(bad_cfg), 0);
        check("t6b_writes", wr_cnt - wr0, 4);
        check("t6b_passes", 32'(pass_count), 1);
        check_dist("t6b", 2, 16'sh7FFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
